// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with sign fix-up at the end.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] input0,
  input  logic [DATA_WIDTH-1:0] input1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [2:0]      op;
  logic [W-1:0]    a_mag, b_mag;
  logic [W-1:0]    hi, lo;
  logic            neg_q, neg_r;
  logic            special;

  logic            is_div, signed0, signed1, sign0, sign1;
  logic [W-1:0]    mag0, mag1;
  logic            div_zero, div_ovf, special_case;
  logic [W-1:0]    special_res;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic            div_ge;
  logic [W-1:0]    div_diff;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix;
  logic [W-1:0]    result;

  // Operand decode at accept: signedness, magnitudes and the no-iteration divide cases.
  always_comb begin
    is_div       = funct3[2];
    signed0      = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
    signed1      = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sign0        = signed0 & input0[W-1];
    sign1        = signed1 & input1[W-1];
    mag0         = sign0 ? -input0 : input0;
    mag1         = sign1 ? -input1 : input1;
    div_zero     = is_div && (input1 == '0);
    div_ovf      = is_div && !funct3[0] && (input0 == {1'b1, {(W-1){1'b0}}}) &&
                   (input1 == '1);
    special_case = div_zero || div_ovf;
    if (div_zero)
      special_res = funct3[1] ? input0 : '1;
    else
      special_res = funct3[1] ? '0 : input0;
  end

  // One iteration step of each algorithm; hi/lo hold product or remainder/quotient.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : '0);
    div_shift = {hi, lo[W-1]};
    div_ge    = div_shift >= {1'b0, b_mag};
    div_diff  = div_shift[W-1:0] - b_mag;
  end

  always_comb begin
    prod_fix = neg_q ? -{hi, lo} : {hi, lo};
    quot_fix = neg_q ? -lo : lo;
    rem_fix  = neg_r ? -hi : hi;
    result   = '0;
    if (special)
      result = lo;
    else
      case (op)
        3'b000:                 result = prod_fix[W-1:0];
        3'b001, 3'b010, 3'b011: result = prod_fix[2*W-1:W];
        3'b100, 3'b101:         result = quot_fix;
        default:                result = rem_fix;
      endcase
  end

  // Special cases still pass through BUSY for one edge so they finalise like normal ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      op        <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      hi        <= '0;
      lo        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      counter   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            op       <= funct3;
            out_tag  <= in_tag;
            a_mag    <= mag0;
            b_mag    <= mag1;
            hi       <= '0;
            neg_q    <= sign0 ^ sign1;
            neg_r    <= sign0;
            state    <= BUSY;
            if (special_case) begin
              special <= 1'b1;
              lo      <= special_res;
              counter <= LAST;
            end else begin
              special <= 1'b0;
              lo      <= is_div ? mag0 : mag1;
              counter <= '0;
            end
          end
        end
        BUSY: begin
          if (counter == LAST) begin
            out       <= result;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            counter <= counter + CW'(1);
            if (op[2]) begin
              hi <= div_ge ? div_diff : div_shift[W-1:0];
              lo <= {lo[W-2:0], div_ge};
            end else begin
              hi <= mul_sum[W:1];
              lo <= {mul_sum[0], lo[W-1:1]};
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
